// File: rtl/uart_rx_8n1_if.sv
// Received-byte bundle from the 8N1 UART receiver to the byte-command consumer.
// The receiver drives the master side and the consumer listens on the slave side.
interface uart_rx_8n1_if;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       rx_frame_err;
    logic       rx_busy;

    modport master (
        output rx_data,
        output rx_done,
        output rx_frame_err,
        output rx_busy
    );

    modport slave (
        input rx_data,
        input rx_done,
        input rx_frame_err,
        input rx_busy
    );
endinterface

// File: rtl/uart_rx_8n1.sv
// 8N1 UART receiver: synchronises the RX pin, samples each bit at mid-bit and
// delivers bytes with a one-cycle done strobe, or flags a bad stop bit.
module uart_rx_8n1 #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 115200
) (
    input  logic            clk_50m,
    input  logic            reset_n,
    input  logic            uart_rxd,
    uart_rx_8n1_if.master   rx
);

    localparam int          BIT_CYCLES  = CLK_FREQ / BAUD;
    localparam int          HALF_CYCLES = BIT_CYCLES / 2;
    localparam logic [15:0] BIT_LAST    = 16'(BIT_CYCLES - 1);
    localparam logic [15:0] HALF_LAST   = 16'(HALF_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t      state;
    state_t      state_next;

    logic        s1;
    logic        s2;
    logic        s3;
    logic        fall_edge;
    logic        half_hit;
    logic        bit_hit;
    logic        last_bit;

    logic [15:0] cnt;
    logic [2:0]  idx;
    logic [7:0]  shift;
    logic [7:0]  data_q;
    logic        done_q;
    logic        err_q;
    logic        busy;

    // Two-flop synchroniser plus a history flop; resetting to 1 keeps an idle
    // line from looking like a start edge when reset is released.
    always_ff @(posedge clk_50m or negedge reset_n) begin
        if (!reset_n) begin
            s1 <= 1'b1;
            s2 <= 1'b1;
            s3 <= 1'b1;
        end else begin
            s1 <= uart_rxd;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign fall_edge = s3 & ~s2;
    assign half_hit  = (cnt == HALF_LAST);
    assign bit_hit   = (cnt == BIT_LAST);
    assign last_bit  = (idx == 3'd7);

    always_ff @(posedge clk_50m or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (fall_edge) begin
                    state_next = START;
                end
            end
            START: begin
                if (half_hit) begin
                    state_next = s2 ? IDLE : DATA;
                end
            end
            DATA: begin
                if (bit_hit && last_bit) begin
                    state_next = STOP;
                end
            end
            STOP: begin
                // Leaving at mid-stop-bit leaves half a bit to catch an
                // immediately following start edge.
                if (bit_hit) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
    end

    always_ff @(posedge clk_50m or negedge reset_n) begin
        if (!reset_n) begin
            cnt    <= 16'd0;
            idx    <= 3'd0;
            shift  <= 8'h00;
            data_q <= 8'h00;
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= 16'd0;
                    idx <= 3'd0;
                end
                START: begin
                    if (half_hit) begin
                        cnt <= 16'd0;
                        idx <= 3'd0;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                DATA: begin
                    if (bit_hit) begin
                        shift[idx] <= s2;
                        cnt        <= 16'd0;
                        if (!last_bit) begin
                            idx <= idx + 3'd1;
                        end
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                STOP: begin
                    if (bit_hit) begin
                        cnt <= 16'd0;
                        if (s2) begin
                            data_q <= shift;
                            done_q <= 1'b1;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                default: begin
                    cnt <= 16'd0;
                    idx <= 3'd0;
                end
            endcase
        end
    end

    assign rx.rx_data      = data_q;
    assign rx.rx_done      = done_q;
    assign rx.rx_frame_err = err_q;
    assign rx.rx_busy      = busy;

endmodule

// File: tb/tb_uart_rx_8n1.sv
// Scoreboard bench for uart_rx_8n1: frames are queued as they are driven and
// matched against rx_done / rx_frame_err pulses seen by the monitor.
module tb_uart_rx_8n1;

    localparam real CPB_NOM   = 434.0;
    localparam int  LATENCY   = 4125;
    localparam int  TOL       = 2;
    localparam int  FRAME_GAP = 4340;

    typedef struct {
        logic [7:0] data;
        bit         is_err;
        int         fall_cycle;
        bit         check_time;
    } exp_t;

    logic clk_50m;
    logic reset_n;
    logic uart_rxd;

    uart_rx_8n1_if rx_if ();

    uart_rx_8n1 #(
        .CLK_FREQ (50_000_000),
        .BAUD     (115200)
    ) dut (
        .clk_50m  (clk_50m),
        .reset_n  (reset_n),
        .uart_rxd (uart_rxd),
        .rx       (rx_if)
    );

    exp_t       sb[$];
    int         done_cycles[$];
    int         checks      = 0;
    int         errors      = 0;
    int         cycle_count = 0;
    bit         prev_pulse  = 1'b0;
    logic [7:0] last_data   = 8'h00;

    initial clk_50m = 1'b0;
    always #10 clk_50m = ~clk_50m;

    always @(posedge clk_50m) cycle_count <= cycle_count + 1;

    // Pops the oldest expected frame whenever the receiver reports a frame end.
    always @(negedge clk_50m) begin
        exp_t e;
        if (rx_if.rx_done || rx_if.rx_frame_err) begin
            checks++;
            if (prev_pulse) begin
                errors++;
                $display("[TB] FAIL pulse_spacing: frame-end pulse on two consecutive cycles at cycle %0d", cycle_count);
            end
            checks++;
            if (rx_if.rx_done && rx_if.rx_frame_err) begin
                errors++;
                $display("[TB] FAIL exclusive: rx_done=1 and rx_frame_err=1 together, required at most one");
            end
            if (rx_if.rx_done) done_cycles.push_back(cycle_count);
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected_pulse: done=%0b err=%0b data=%h at cycle %0d, required no pulse",
                         rx_if.rx_done, rx_if.rx_frame_err, rx_if.rx_data, cycle_count);
            end else begin
                e = sb.pop_front();
                if (rx_if.rx_frame_err !== e.is_err) begin
                    errors++;
                    $display("[TB] FAIL pulse_kind: rx_frame_err=%0b, required %0b", rx_if.rx_frame_err, e.is_err);
                end
                checks++;
                if (rx_if.rx_data !== e.data) begin
                    errors++;
                    $display("[TB] FAIL rx_data: got %h, required %h", rx_if.rx_data, e.data);
                end
                if (e.check_time) begin
                    checks++;
                    if ((cycle_count - e.fall_cycle) < LATENCY - TOL ||
                        (cycle_count - e.fall_cycle) > LATENCY + TOL) begin
                        errors++;
                        $display("[TB] FAIL latency: got %0d cycles, required %0d +/- %0d",
                                 cycle_count - e.fall_cycle, LATENCY, TOL);
                    end
                end
            end
        end
        prev_pulse = rx_if.rx_done || rx_if.rx_frame_err;
    end

    task automatic drive_frame(input logic [7:0] data, input real cpb, input logic stop_val,
                               input bit expect_err, input bit check_time);
        exp_t       e;
        logic [9:0] bits;
        int         edges = 0;
        int         target;
        bits         = {stop_val, data, 1'b0};
        e.data       = expect_err ? last_data : data;
        e.is_err     = expect_err;
        e.fall_cycle = cycle_count;
        e.check_time = check_time;
        if (!expect_err) last_data = data;
        sb.push_back(e);
        for (int i = 0; i < 10; i++) begin
            uart_rxd = bits[i];
            target   = $rtoi((i + 1) * cpb + 0.5);
            while (edges < target) begin
                @(posedge clk_50m);
                edges++;
            end
            #1;
        end
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(posedge clk_50m);
            n++;
        end
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("[TB] FAIL %s_timeout: %0d frames still pending, required 0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk_50m);
        #1;
    endtask

    task automatic test_reset();
        reset_n  = 1'b0;
        uart_rxd = 1'b1;
        idle_cycles(5);
        checks++;
        if ({rx_if.rx_data, rx_if.rx_done, rx_if.rx_frame_err, rx_if.rx_busy} !== 11'h000) begin
            errors++;
            $display("[TB] FAIL reset_outputs: data=%h done=%0b err=%0b busy=%0b, required all 0",
                     rx_if.rx_data, rx_if.rx_done, rx_if.rx_frame_err, rx_if.rx_busy);
        end
        reset_n = 1'b1;
        idle_cycles(20);
        checks++;
        if (rx_if.rx_busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL idle_after_reset: rx_busy=%0b, required 0", rx_if.rx_busy);
        end
    endtask

    task automatic test_single_frame();
        $display("[TB] single frame 0xA5");
        drive_frame(8'hA5, CPB_NOM, 1'b1, 1'b0, 1'b1);
        wait_drain("single", 1000);
        checks++;
        if (rx_if.rx_data !== 8'hA5) begin
            errors++;
            $display("[TB] FAIL single_hold: rx_data=%h, required a5", rx_if.rx_data);
        end
        idle_cycles(200);
    endtask

    task automatic test_back_to_back();
        logic [7:0] pattern [3] = '{8'h00, 8'hFF, 8'h05};
        $display("[TB] back-to-back 00 FF 05");
        done_cycles.delete();
        foreach (pattern[i]) drive_frame(pattern[i], CPB_NOM, 1'b1, 1'b0, 1'b1);
        wait_drain("b2b", 1000);
        checks++;
        if (done_cycles.size() != 3) begin
            errors++;
            $display("[TB] FAIL b2b_count: got %0d done pulses, required 3", done_cycles.size());
        end else begin
            for (int i = 1; i < 3; i++) begin
                checks++;
                if (done_cycles[i] - done_cycles[i-1] < FRAME_GAP - TOL ||
                    done_cycles[i] - done_cycles[i-1] > FRAME_GAP + TOL) begin
                    errors++;
                    $display("[TB] FAIL b2b_gap: got %0d cycles, required %0d +/- %0d",
                             done_cycles[i] - done_cycles[i-1], FRAME_GAP, TOL);
                end
            end
        end
        idle_cycles(200);
    endtask

    task automatic test_glitch();
        int busy_cnt = 0;
        $display("[TB] 100-cycle glitch");
        for (int i = 0; i < 600; i++) begin
            @(negedge clk_50m);
            if (i == 0)   uart_rxd = 1'b0;
            if (i == 100) uart_rxd = 1'b1;
            if (rx_if.rx_busy) busy_cnt++;
        end
        checks++;
        if (busy_cnt < 217 - TOL || busy_cnt > 217 + TOL) begin
            errors++;
            $display("[TB] FAIL glitch_busy: busy for %0d cycles, required 217 +/- %0d", busy_cnt, TOL);
        end
        checks++;
        if (rx_if.rx_busy !== 1'b0 || rx_if.rx_data !== last_data) begin
            errors++;
            $display("[TB] FAIL glitch_after: busy=%0b data=%h, required busy 0 data %h",
                     rx_if.rx_busy, rx_if.rx_data, last_data);
        end
        @(posedge clk_50m);
        #1;
    endtask

    task automatic test_frame_error();
        $display("[TB] framing error then break");
        drive_frame(8'h3C, CPB_NOM, 1'b0, 1'b1, 1'b1);
        uart_rxd = 1'b0;
        idle_cycles(20 * 434);
        wait_drain("ferr", 10);
        checks++;
        if (rx_if.rx_busy !== 1'b0 || rx_if.rx_data !== 8'h05) begin
            errors++;
            $display("[TB] FAIL break_hold: busy=%0b data=%h, required busy 0 data 05",
                     rx_if.rx_busy, rx_if.rx_data);
        end
        uart_rxd = 1'b1;
        idle_cycles(2 * 434);
        drive_frame(8'h01, CPB_NOM, 1'b1, 1'b0, 1'b1);
        wait_drain("after_break", 1000);
        checks++;
        if (rx_if.rx_data !== 8'h01) begin
            errors++;
            $display("[TB] FAIL after_break: rx_data=%h, required 01", rx_if.rx_data);
        end
        idle_cycles(200);
    endtask

    task automatic test_reset_mid_frame();
        $display("[TB] reset during bit 4 of 0xFF");
        uart_rxd = 1'b0;
        idle_cycles(434);
        uart_rxd = 1'b1;
        idle_cycles(4 * 434 + 200);
        reset_n = 1'b0;
        #1;
        checks++;
        if ({rx_if.rx_data, rx_if.rx_done, rx_if.rx_frame_err, rx_if.rx_busy} !== 11'h000) begin
            errors++;
            $display("[TB] FAIL midframe_reset: data=%h done=%0b err=%0b busy=%0b, required all 0",
                     rx_if.rx_data, rx_if.rx_done, rx_if.rx_frame_err, rx_if.rx_busy);
        end
        last_data = 8'h00;
        idle_cycles(10);
        reset_n = 1'b1;
        idle_cycles(5000);
        checks++;
        if (rx_if.rx_busy !== 1'b0 || rx_if.rx_data !== 8'h00) begin
            errors++;
            $display("[TB] FAIL post_reset_idle: busy=%0b data=%h, required busy 0 data 00",
                     rx_if.rx_busy, rx_if.rx_data);
        end
        drive_frame(8'h03, CPB_NOM, 1'b1, 1'b0, 1'b1);
        wait_drain("post_reset", 1000);
        idle_cycles(200);
    endtask

    task automatic test_baud_skew();
        $display("[TB] baud skew 117500 / 112900");
        drive_frame(8'h5A, 50_000_000.0 / 117500.0, 1'b1, 1'b0, 1'b0);
        wait_drain("skew_fast", 1000);
        idle_cycles(300);
        drive_frame(8'h5A, 50_000_000.0 / 112900.0, 1'b1, 1'b0, 1'b0);
        wait_drain("skew_slow", 1000);
        checks++;
        if (rx_if.rx_data !== 8'h5A) begin
            errors++;
            $display("[TB] FAIL skew_data: rx_data=%h, required 5a", rx_if.rx_data);
        end
        idle_cycles(200);
    endtask

    initial begin
        reset_n  = 1'b0;
        uart_rxd = 1'b1;
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_glitch();
        test_frame_error();
        test_reset_mid_frame();
        test_baud_skew();
        idle_cycles(5000);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
